// File: rtl/pwm_pkg.sv
// Shared constants and state type for the PWM link (generator and capture sides).
package pwm_pkg;

   localparam int unsigned CNT_W_DFLT = 8;
   localparam int unsigned DIV_W_DFLT = 12;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_e;

   // Cycles without a rising edge before the line is declared stuck.
   function automatic int unsigned timeout_cycles(input int unsigned cnt_w, input int unsigned div_w);
      return 32'd1 << (cnt_w + div_w + 1);
   endfunction

   // Half a tick in CLK cycles, used to round a cycle count to whole ticks.
   function automatic int unsigned round_half(input int unsigned div_w);
      return 32'd1 << (div_w - 1);
   endfunction

   localparam int unsigned TIMEOUT = timeout_cycles(CNT_W_DFLT, DIV_W_DFLT);
   localparam int unsigned ROUND   = round_half(DIV_W_DFLT);

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchroniser for an asynchronous pin plus registered rise/fall pulses.
// Edges are suppressed until the pipeline holds real samples, so reset never fakes an edge.
module pwm_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall,
   output logic level
);

   logic       meta_q, meta_d;
   logic       sync_q, sync_d;
   logic       dly_q, dly_d;
   logic [2:0] prime_q, prime_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;

   always_comb begin
      meta_d  = din;
      sync_d  = meta_q;
      dly_d   = sync_q;
      prime_d = {prime_q[1:0], 1'b1};
      rise_d  = prime_q[2] & sync_q & ~dly_q;
      fall_d  = prime_q[2] & ~sync_q & dly_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         dly_q   <= 1'b0;
         prime_q <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         dly_q   <= dly_d;
         prime_q <= prime_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign rise  = rise_q;
   assign fall  = fall_q;
   assign level = dly_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Recovers the duty word from an incoming PWM line by timing high and period in CLK cycles.
// Optional period tolerance check enabled with `define PERIOD_CHECK_EN.
//
// state | meaning
// SYNC  | waiting for a rising edge (after reset or after a stuck line)
// HIGH  | line high, counting high time and period
// LOW   | line low, counting period until the next rise closes it
module pwm_duty_capture
   import pwm_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DFLT,
   parameter int unsigned CNT_W = CNT_W_DFLT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PWM_IN,
   output logic [CNT_W-1:0] DUTY,
   output logic             DUTY_VLD,
   output logic             STUCK,
   output logic             PERIOD_ERR
);

   localparam int unsigned      CW       = CNT_W + DIV_W + 1;
   localparam logic [CW:0]      TMO_LAST = (CW+1)'(timeout_cycles(CNT_W, DIV_W) - 1);
   localparam logic [CW:0]      RND      = (CW+1)'(round_half(DIV_W));
   localparam logic [CW:0]      DUTY_LIM = (CW+1)'((1 << CNT_W) - 1);
   localparam logic [CNT_W-1:0] DUTY_MAX = '1;
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   logic rise, fall, level;

   pwm_in_sync u_sync (
      .clk   (CLK),
      .rst   (RST),
      .din   (PWM_IN),
      .rise  (rise),
      .fall  (fall),
      .level (level)
   );

   pwm_state_e       state_q, state_d;
   logic [CW-1:0]    per_cnt_q, per_cnt_d;
   logic [CW-1:0]    hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             duty_vld_q, duty_vld_d;
   logic             stuck_q, stuck_d;
   logic             timeout;
   logic [CW:0]      hi_sum, hi_shift;
   logic [CNT_W-1:0] hi_duty;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign hi_sum   = {1'b0, hi_cnt_q} + RND;
   assign hi_shift = hi_sum >> DIV_W;
   assign hi_duty  = (hi_shift > DUTY_LIM) ? DUTY_MAX : hi_shift[CNT_W-1:0];

`ifdef PERIOD_CHECK_EN
   localparam logic [CW:0] PER_NOM = (CW+1)'(1 << CNT_W);
   logic        period_err_q, period_err_d;
   logic [CW:0] per_sum, per_shift;
   assign per_sum   = {1'b0, per_cnt_q} + RND;
   assign per_shift = per_sum >> DIV_W;
`endif

   always_comb begin
      state_d    = state_q;
      per_cnt_d  = sat_inc(per_cnt_q);
      hi_cnt_d   = hi_cnt_q;
      duty_d     = duty_q;
      duty_vld_d = 1'b0;
      stuck_d    = stuck_q;
`ifdef PERIOD_CHECK_EN
      period_err_d = 1'b0;
`endif
      // Once stuck, the counter just saturates until the line moves again.
      timeout = !stuck_q && !rise && ({1'b0, per_cnt_q} == TMO_LAST);

      unique case (state_q)
         SYNC: begin
            if (rise) begin
               state_d   = HIGH;
               per_cnt_d = CNT_ONE;
               hi_cnt_d  = CNT_ONE;
               stuck_d   = 1'b0;
            end
         end
         HIGH: begin
            if (fall) state_d  = LOW;
            else      hi_cnt_d = sat_inc(hi_cnt_q);
         end
         LOW: begin
            if (rise) begin
`ifdef PERIOD_CHECK_EN
               if (per_shift != PER_NOM) begin
                  period_err_d = 1'b1;
               end else begin
                  duty_d     = hi_duty;
                  duty_vld_d = 1'b1;
               end
`else
               duty_d     = hi_duty;
               duty_vld_d = 1'b1;
`endif
               state_d   = HIGH;
               per_cnt_d = CNT_ONE;
               hi_cnt_d  = CNT_ONE;
            end
         end
         default: state_d = SYNC;
      endcase

      // A silent line still carries a duty: low means 0, high means full scale.
      if (timeout) begin
         duty_d     = level ? DUTY_MAX : '0;
         duty_vld_d = 1'b1;
         stuck_d    = 1'b1;
         state_d    = SYNC;
         per_cnt_d  = '0;
         hi_cnt_d   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= SYNC;
         per_cnt_q  <= '0;
         hi_cnt_q   <= '0;
         duty_q     <= '0;
         duty_vld_q <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_cnt_q  <= per_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
         duty_q     <= duty_d;
         duty_vld_q <= duty_vld_d;
         stuck_q    <= stuck_d;
      end
   end

`ifdef PERIOD_CHECK_EN
   always_ff @(posedge CLK) begin
      if (RST) period_err_q <= 1'b0;
      else     period_err_q <= period_err_d;
   end
   assign PERIOD_ERR = period_err_q;
`else
   assign PERIOD_ERR = 1'b0;
`endif

   assign DUTY     = duty_q;
   assign DUTY_VLD = duty_vld_q;
   assign STUCK    = stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: behavioural PWM sender with random divider phase and a scoreboard of
// expected duty reports, plus hand-written stuck-line, reset and (optionally) period-error sequences.
module tb_pwm_duty_capture;

   localparam int DIV_W   = 4;
   localparam int CNT_W   = 8;
   localparam int PER_CYC = 4096;
   localparam int TMO     = 8192;

   logic             CLK    = 1'b0;
   logic             RST    = 1'b1;
   logic             PWM_IN = 1'b0;
   logic [CNT_W-1:0] DUTY;
   logic             DUTY_VLD;
   logic             STUCK;
   logic             PERIOD_ERR;

   always #5 CLK = ~CLK;

   pwm_duty_capture #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PWM_IN     (PWM_IN),
      .DUTY       (DUTY),
      .DUTY_VLD   (DUTY_VLD),
      .STUCK      (STUCK),
      .PERIOD_ERR (PERIOD_ERR)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_checks++;
      if (got >= lo && got <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
   endtask

   // ---------------- sender model and scoreboard producer ----------------
   int  duty_req     = 128;
   int  duty_cur     = 128;
   int  period_ticks = 256;
   int  cur_len      = 256;
   int  div_cnt      = 0;
   int  tick_cnt     = 0;
   int  last_rise_cyc = 0;
   int  exp_perr     = 0;
   int  got_perr     = 0;
   int  vld_cnt      = 0;
   bit  meas_valid   = 1'b0;
   int  exp_q[$];

   initial begin
      div_cnt = int'($urandom_range(0, 15));
      forever begin
         bit pwm_new;
         int done_len;
         @(posedge CLK);
         #2;
         if (RST) begin
            meas_valid = 1'b0;
            exp_q.delete();
         end
         if (div_cnt == (1 << DIV_W) - 1) begin
            div_cnt = 0;
            if (tick_cnt == cur_len - 1) begin
               tick_cnt = 0;
               done_len = cur_len;
               cur_len  = period_ticks;
               if (duty_req != 0) begin
                  if (meas_valid) begin
`ifdef PERIOD_CHECK_EN
                     if (done_len != 256) exp_perr++;
                     else
`endif
                     exp_q.push_back(duty_cur);
                  end
                  meas_valid = 1'b1;
               end else if (duty_cur != 0 && meas_valid) begin
                  exp_q.push_back(0);
                  meas_valid = 1'b0;
               end
               duty_cur = duty_req;
            end else begin
               tick_cnt++;
            end
         end else begin
            div_cnt++;
         end
         pwm_new = (tick_cnt < duty_cur);
         if (pwm_new && !PWM_IN) last_rise_cyc = cyc;
         PWM_IN = pwm_new;
      end
   end

   // ---------------- scoreboard consumer and output invariants ----------------
   initial begin
      int prev_duty;
      int e;
      prev_duty = 0;
      forever begin
         @(negedge CLK);
         if (DUTY_VLD) begin
            vld_cnt++;
            check("vld_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("vld_duty", int'(DUTY), e);
            end
         end else if (!RST) begin
            check("duty_hold_without_vld", int'(DUTY), prev_duty);
         end
         if (PERIOD_ERR) got_perr++;
`ifndef PERIOD_CHECK_EN
         if (PERIOD_ERR) check("period_err_tied_low", int'(PERIOD_ERR), 0);
`endif
         prev_duty = int'(DUTY);
      end
   end

   task automatic wait_tick(input int t);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3 * PER_CYC; i++) begin
         @(posedge CLK);
         #1;
         if (tick_cnt == t) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_tick_reached", int'(ok), 1);
   endtask

   typedef struct {
      int duty;
      int exp_duty;
   } step_t;

   step_t tbl[5];

   initial begin
      int base;
      int t0;
      bit seen;

      tbl[0] = '{duty: 128, exp_duty: 128};
      tbl[1] = '{duty: 1,   exp_duty: 1};
      tbl[2] = '{duty: 255, exp_duty: 255};
      tbl[3] = '{duty: 64,  exp_duty: 64};
      tbl[4] = '{duty: 200, exp_duty: 200};

      repeat (5) @(posedge CLK);
      @(negedge CLK);
      check("rst_duty", int'(DUTY), 0);
      check("rst_vld", int'(DUTY_VLD), 0);
      check("rst_stuck", int'(STUCK), 0);
      check("rst_period_err", int'(PERIOD_ERR), 0);

      wait_tick(100);
      RST = 1'b0;

      for (int i = 0; i < 5; i++) begin
         duty_req = tbl[i].duty;
         base = vld_cnt;
         repeat (2 * PER_CYC + 50) @(posedge CLK);
         @(negedge CLK);
         check($sformatf("step%0d_duty", i), int'(DUTY), tbl[i].exp_duty);
         check($sformatf("step%0d_stuck", i), int'(STUCK), 0);
         check($sformatf("step%0d_vld_seen", i), int'(vld_cnt > base), 1);
      end

      // Line goes silent low: expect one zero report and STUCK.
      duty_req = 0;
      seen = 1'b0;
      for (int i = 0; i < PER_CYC + TMO + 300; i++) begin
         @(negedge CLK);
         if (STUCK) begin
            seen = 1'b1;
            break;
         end
      end
      check("stuck_set", int'(seen), 1);
      check_range("stuck_delay_from_last_rise", cyc - last_rise_cyc, TMO - 8, TMO + 12);
      check("stuck_duty", int'(DUTY), 0);
      base = vld_cnt;
      repeat (PER_CYC) @(posedge CLK);
      @(negedge CLK);
      check("stuck_held", int'(STUCK), 1);
      check("stuck_no_more_vld", vld_cnt - base, 0);

      // Line comes back: next rise clears STUCK, one period later duty reported.
      duty_req = 10;
      seen = 1'b0;
      for (int i = 0; i < PER_CYC + 200; i++) begin
         @(negedge CLK);
         if (!STUCK) begin
            seen = 1'b1;
            break;
         end
      end
      check("stuck_cleared", int'(seen), 1);
      repeat (2 * PER_CYC + 50) @(posedge CLK);
      @(negedge CLK);
      check("recover_duty", int'(DUTY), 10);

      // Reset while the line is high (FSM in HIGH).
      duty_req = 128;
      repeat (2 * PER_CYC + 50) @(posedge CLK);
      wait_tick(50);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("midrst_duty", int'(DUTY), 0);
      check("midrst_vld", int'(DUTY_VLD), 0);
      check("midrst_stuck", int'(STUCK), 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      t0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 3 * PER_CYC; i++) begin
         @(negedge CLK);
         if (DUTY_VLD) begin
            seen = 1'b1;
            break;
         end
      end
      check("midrst_vld_returns", int'(seen), 1);
      check_range("midrst_first_vld_delay", cyc - t0, PER_CYC, 2 * PER_CYC + 10);
      check("midrst_duty_after", int'(DUTY), 128);

`ifdef PERIOD_CHECK_EN
      begin
         int perr_base;
         int exp_base;
         perr_base = got_perr;
         exp_base  = exp_perr;
         period_ticks = 300;
         repeat (3 * 300 * 16 + 50) @(posedge CLK);
         @(negedge CLK);
         check("perr_count", got_perr - perr_base, exp_perr - exp_base);
         check("perr_seen", int'((got_perr - perr_base) > 0), 1);
         check("perr_duty_kept", int'(DUTY), 128);
         period_ticks = 256;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
